// File: rtl/launch_pkg.sv
// Package: launch_pkg
// Shared types for the processor launch controller.
//   launch_state_t  : sequencer state (IDLE -> PRST -> STRT -> RUN -> FINISH -> IDLE)
//   launch_status_t : completion status reported to the host
package launch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        STRT,
        RUN,
        FINISH
    } launch_state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ABORT   = 2'b10
    } launch_status_t;

endpackage

// File: rtl/launch_cycle_counter.sv
// Module: launch_cycle_counter
// Saturating up-counter used both as the PRST/STRT phase timer and as the RUN counter.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   clear    in   synchronous clear (priority over enable)
//   enable   in   count one step this cycle
//   limit    in   saturation value; the counter never advances past it
//   count    out  current count
//   at_limit out  count == limit
module launch_cycle_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !at_limit) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == limit);

endmodule

// File: rtl/proc_launch_controller.sv
// Module: proc_launch_controller
// Host-side sequencer in front of the core's start/ack interface: on req it holds the core in
// reset, drives the start pulse, counts RUN cycles until ack, enforces a timeout and reports
// status/cycle count. All outputs are registered.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, abort          host launch request (IDLE only) / abort (PRST, STRT, RUN)
//   busy, done          not-IDLE flag / one-cycle completion pulse
//   status, cycles      result of last run (00 ok, 01 timeout, 10 aborted), RUN-cycle count
//   proc_reset, start   drive the core
//   ack                 completion from the core, only looked at in RUN
//   run_count, max_run  launch statistics, present only with LAUNCH_STATS_EN defined
// Configuration macro: LAUNCH_STATS_EN
module proc_launch_controller
    import launch_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycles,
`ifdef LAUNCH_STATS_EN
    output logic [CNT_W-1:0] run_count,
    output logic [CNT_W-1:0] max_run,
`endif
    output logic             proc_reset,
    output logic             start,
    input  logic             ack
);

    launch_state_t  state_q, state_d;
    launch_status_t status_q, fin_status;
    logic [CNT_W-1:0] cycles_q, fin_cycles;
    logic busy_q, done_q, proc_reset_q, start_q;

    logic [CNT_W-1:0] phase_cnt, phase_limit, run_cnt;
    logic phase_at_limit, run_at_limit, phase_clear, in_phase, fin;

    assign in_phase    = (state_q == PRST) || (state_q == STRT);
    // Phase timer restarts on every state change so PRST and STRT each get a fresh count.
    assign phase_clear = !in_phase || (state_d != state_q);
    assign phase_limit = (state_q == PRST) ? CNT_W'(RESET_CYCLES - 1) : CNT_W'(START_CYCLES - 1);

    launch_cycle_counter #(.WIDTH(CNT_W)) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (phase_clear),
        .enable   (1'b1),
        .limit    (phase_limit),
        .count    (phase_cnt),
        .at_limit (phase_at_limit)
    );

    // Holds RUN cycles completed before the current one; the current cycle is run_cnt + 1.
    launch_cycle_counter #(.WIDTH(CNT_W)) u_run_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q != RUN),
        .enable   (state_q == RUN),
        .limit    (CNT_W'(MAX_CYCLES - 1)),
        .count    (run_cnt),
        .at_limit (run_at_limit)
    );

    logic unused_phase_cnt;
    assign unused_phase_cnt = ^phase_cnt;

    always_comb begin
        state_d    = state_q;
        fin_status = ST_OK;
        fin_cycles = '0;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = PRST;
            end
            PRST: begin
                if (abort) begin
                    state_d    = FINISH;
                    fin_status = ST_ABORT;
                end else if (phase_at_limit) begin
                    state_d = STRT;
                end
            end
            STRT: begin
                if (abort) begin
                    state_d    = FINISH;
                    fin_status = ST_ABORT;
                end else if (phase_at_limit) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                fin_cycles = run_cnt + CNT_W'(1);
                // abort beats ack, ack beats timeout
                if (abort) begin
                    state_d    = FINISH;
                    fin_status = ST_ABORT;
                end else if (ack) begin
                    state_d    = FINISH;
                    fin_status = ST_OK;
                end else if (run_at_limit) begin
                    state_d    = FINISH;
                    fin_status = ST_TIMEOUT;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fin = (state_d == FINISH);

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            proc_reset_q <= 1'b0;
            start_q      <= 1'b0;
            status_q     <= ST_OK;
            cycles_q     <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != IDLE);
            done_q       <= fin;
            proc_reset_q <= (state_d == PRST);
            start_q      <= (state_d == STRT);
            if (fin) begin
                status_q <= fin_status;
                cycles_q <= fin_cycles;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign proc_reset = proc_reset_q;
    assign start      = start_q;
    assign status     = status_q;
    assign cycles     = cycles_q;

`ifdef LAUNCH_STATS_EN
    logic [CNT_W-1:0] run_count_q, max_run_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_count_q <= '0;
            max_run_q   <= '0;
        end else if (fin) begin
            if (run_count_q != '1) run_count_q <= run_count_q + CNT_W'(1);
            if (fin_status == ST_OK && fin_cycles > max_run_q) max_run_q <= fin_cycles;
        end
    end

    assign run_count = run_count_q;
    assign max_run   = max_run_q;
`endif

endmodule

// File: tb/tb_proc_launch_controller.sv
// Testbench for proc_launch_controller: randomized and directed launches, a reference model
// producing expected {status, cycles, done time} per launch, and a done-driven monitor.
module tb_proc_launch_controller;

    localparam int CNT_W = 16;
    localparam int RC    = 2;
    localparam int SC    = 2;
    localparam int MAXC  = 4096;
    localparam int PH    = RC + SC;

    logic clk = 1'b0;
    logic reset, req, abort, ack;
    logic busy, done, proc_reset, start;
    logic [1:0] status;
    logic [CNT_W-1:0] cycles;
`ifdef LAUNCH_STATS_EN
    logic [CNT_W-1:0] run_count, max_run;
`endif

    proc_launch_controller #(
        .CNT_W        (CNT_W),
        .RESET_CYCLES (RC),
        .START_CYCLES (SC),
        .MAX_CYCLES   (MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .cycles     (cycles),
`ifdef LAUNCH_STATS_EN
        .run_count  (run_count),
        .max_run    (max_run),
`endif
        .proc_reset (proc_reset),
        .start      (start),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int status;
        int cycles;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int launches = 0;
    int rises = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model. ack_k: first RUN cycle with ack held high (0 = never).
    // abort_j: launch cycle of a one-cycle abort (1-based, PRST starts at 1; 0 = none).
    // Returns the result and the launch cycle in which the run terminates.
    task automatic model(input int ack_k, input int abort_j, output exp_t e, output int term);
        int run_abort, end_k;
        if (abort_j != 0 && abort_j <= PH) begin
            e.status = 2;
            e.cycles = 0;
            term     = abort_j;
            return;
        end
        run_abort = (abort_j == 0) ? 0 : abort_j - PH;
        end_k = MAXC;
        if (ack_k != 0 && ack_k < end_k) end_k = ack_k;
        if (run_abort != 0 && run_abort < end_k) end_k = run_abort;
        if (run_abort == end_k) e.status = 2;
        else if (ack_k == end_k) e.status = 0;
        else e.status = 1;
        e.cycles = end_k;
        term     = PH + end_k;
    endtask

    task automatic run(input int ack_k, input int abort_j, input bit stale, input bit noise);
        exp_t e;
        int term, c0;
        model(ack_k, abort_j, e, term);
        req = 1'b1;
        ack = stale;
        @(posedge clk);
        #1;
        c0 = cyc;
        e.done_cyc = c0 + term;
        sb.push_back(e);
        launches++;
        for (int j = 1; j <= term + 1; j++) begin
            abort = (j == abort_j);
            if (j <= PH) ack = stale ? 1'b1 : 1'($urandom_range(0, 1));
            else ack = (ack_k != 0 && j - PH >= ack_k);
            req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        req   = 1'b0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_seen", sb.size(), 0);
        sb.delete();
    endtask

    task automatic reset_midrun();
        req = 1'b1;
        ack = 1'b0;
        @(posedge clk);
        #1;
        launches++;
        for (int j = 1; j <= PH + 3; j++) begin
            req   = 1'($urandom_range(0, 1));
            reset = (j == PH + 3);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        req   = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_proc_reset", proc_reset, 0);
        check("rst_start", start, 0);
        check("rst_status", status, 0);
        check("rst_cycles", cycles, 0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_relaunch", busy, 0);
    endtask

    // Monitor: scoreboard pop on done, pulse-width and busy checks.
    int pr_len = 0;
    int st_len = 0;
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            pr_len    = 0;
            st_len    = 0;
            prev_done = 1'b0;
        end else begin
            if (proc_reset) begin
                if (pr_len == 0) rises++;
                pr_len++;
            end else if (pr_len != 0) begin
                if (start) check("proc_reset_width", pr_len, RC);
                pr_len = 0;
            end
            if (start) begin
                st_len++;
            end else if (st_len != 0) begin
                if (!done) check("start_width", st_len, SC);
                st_len = 0;
            end
            if (prev_done) check("busy_after_done", busy, 0);
            if (done) begin
                exp_t e;
                check("busy_in_finish", busy, 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("status", status, e.status);
                    check("cycles", cycles, e.cycles);
                    check("done_time", cyc, e.done_cyc);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        abort = 1'b0;
        ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_proc_reset", proc_reset, 0);
        check("init_start", start, 0);
        check("init_status", status, 0);
        check("init_cycles", cycles, 0);
`ifdef LAUNCH_STATS_EN
        check("init_run_count", run_count, 0);
        check("init_max_run", max_run, 0);
`endif
        // abort in IDLE is ignored
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort_ignored", busy, 0);

        run(10, 0, 1'b0, 1'b0);          // ack on RUN cycle 10
        run(0, 0, 1'b0, 1'b0);           // timeout
        run(1, 0, 1'b1, 1'b0);           // stale ack through PRST/STRT
        run(5, PH + 5, 1'b0, 1'b0);      // abort and ack together on RUN cycle 5
        run(MAXC, 0, 1'b0, 1'b0);        // ack at the timeout boundary
        run(MAXC, PH + MAXC, 1'b0, 1'b0);// abort at the timeout boundary
        run(3, 1, 1'b0, 1'b0);           // abort in PRST
        run(3, RC + 2, 1'b0, 1'b0);      // abort in STRT
        for (int i = 0; i < 16; i++) begin
            int ak, aj;
            ak = $urandom_range(1, 30);
            aj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, PH + 30) : 0;
            run(ak, aj, 1'($urandom_range(0, 1)), 1'b1);
        end
        reset_midrun();
`ifdef LAUNCH_STATS_EN
        run(7, 0, 1'b0, 1'b0);
        run(4, 0, 1'b0, 1'b0);
        check("stats_run_count_2", run_count, 2);
        check("stats_max_run_7", max_run, 7);
        run(0, 0, 1'b0, 1'b0);
        check("stats_run_count_3", run_count, 3);
        check("stats_max_run_kept", max_run, 7);
`endif
        check("launch_count", rises, launches);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
